// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with HI/LO registers.
// Ports: clk, rst (async active-low), start, op[2:0], dataA, dataB, flush
//        -> busy, done, div_zero, hi, lo (all registered).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   a_raw;
    logic               neg_res;
    logic               neg_rem;
    logic               is_div;
    logic               b_zero;

    logic               accept;
    logic               sgn_op;
    logic               sa;
    logic               sb;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept = start && !flush;

    // MULT and DIV are the even opcodes; op[0] marks the unsigned forms.
    assign sgn_op = ~op[0];
    assign sa     = sgn_op & dataA[WIDTH-1];
    assign sb     = sgn_op & dataB[WIDTH-1];

    // Shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right, carry included.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                    + {1'b0, (prod[0] ? ma : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // Restoring step: the dividend drains out of the top of quo while
    // quotient bits enter at the bottom.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mb};
    assign rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, mb})
                              : div_shift[WIDTH-1:0];

    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -quo : quo;
    assign rem_fix  = neg_rem ? -rem : rem;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_n = MUL;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
                        state_n = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt == LAST) begin
                    state_n = FIX;
                end
            end
            FIX: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            ma       <= '0;
            mb       <= '0;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
            a_raw    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                cnt     <= '0;
                                ma      <= sa ? -dataA : dataA;
                                mb      <= sb ? -dataB : dataB;
                                prod    <= {{WIDTH{1'b0}},
                                            (sb ? -dataB : dataB)};
                                quo     <= sa ? -dataA : dataA;
                                rem     <= '0;
                                a_raw   <= dataA;
                                neg_res <= sa ^ sb;
                                neg_rem <= sa;
                                is_div  <= op[1];
                                b_zero  <= (dataB == '0);
                            end
                            OP_MTHI: begin
                                hi   <= dataA;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= dataA;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + 1'b1;
                end
                DIV: begin
                    quo <= {quo[WIDTH-2:0], div_ge};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (b_zero) begin
                            hi       <= a_raw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers, replacing the single-function multiplier and HI/LO pair in the pipelined core's execute stage. It accepts one operation per start pulse and computes signed or unsigned multiply and divide over `WIDTH` iterations. While it works it drives a busy handshake so hazard logic can stall dependent `mfhi`/`mflo` instructions. It supports pipeline flush (abort without architectural update) and `mthi`/`mtlo` writes.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `dataA`  in  WIDTH  multiplicand, dividend, or MTHI/MTLO source.
- `dataB`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  abort the in-flight operation and discard the start request.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  single-cycle pulse; HI/LO were updated at the preceding edge.
- `div_zero`  out  1  valid with `done`; the divide had a zero divisor.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States are IDLE, MUL, DIV and FIX. The iteration counter is ceil(log2(WIDTH))+1 bits.
- IDLE:
  - `start` with MULT/MULTU latches operands, clears the counter, and enters MUL.
  - `start` with DIV/DIVU latches operands, clears the counter, and enters DIV.
  - MTHI/MTLO write `hi`/`lo` at that edge, pulse `done`, and remain in IDLE.
  - A no-op `op` causes no change.
- Operand latching:
  - Signed ops store operand magnitudes plus a result-sign bit (multiply) or a quotient-sign bit and a remainder-sign bit (divide).
  - The remainder sign is the sign of the dividend.
- MUL is radix-2 shift-add.
  - It uses a 2·WIDTH-bit product accumulator, adding one partial product per cycle.
  - After WIDTH cycles it goes to FIX.
- DIV is restoring division.
  - It produces one quotient bit per cycle into a WIDTH-bit quotient and a WIDTH+1-bit partial remainder.
  - After WIDTH cycles it goes to FIX.
- FIX applies two's-complement sign correction and writes the results, then returns to IDLE with `done`=1.
  - Multiply: `hi` receives product[2W-1:W] and `lo` receives product[W-1:0].
  - Divide: `lo` receives the quotient and `hi` the remainder.
- Divide arithmetic rules:
  - The quotient truncates toward zero.
  - A signed overflow (most-negative / −1) yields `lo`=most-negative and `hi`=0, with no flag.
- Divisor zero, for either signedness:
  - Full latency still applies.
  - `lo` receives all-ones and `hi` receives `dataA` unmodified.
  - `div_zero`=1 alongside `done`.
- `start` is ignored while `busy`=1. The pipeline must hold the instruction.
- `flush`:
  - In MUL, DIV or FIX, the unit returns to IDLE at the next edge. No `done` is produced and `hi`/`lo` are unchanged.
  - In IDLE, `flush` suppresses a simultaneous `start`, including MTHI/MTLO.
- Reset (async low) clears everything:
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
  - Reset mid-operation aborts it with no update.

## Timing
- Take the start edge as E0.
- Multiply and divide:
  - `busy`=1 from after E0 through E(WIDTH+1).
  - `hi`, `lo`, `done` and `div_zero` update at E(WIDTH+1).
  - Latency is WIDTH+1 cycles; for WIDTH=32 this is 33.
- MTHI/MTLO update at E0, `done`=1 for the following cycle, and `busy` stays 0.
- `done` and `div_zero` are registered and held for exactly one cycle. `div_zero` is 0 whenever `done` is 0.
- Back-to-back: a `start` that is high during the `done` cycle is accepted, since the state is IDLE. There is no dead cycle.
- `hi` and `lo` are registered outputs and change only at the edges named above.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then MULT with A=32'hFFFFFFFD, B=7:
  - `busy` for 33 cycles.
  - `done` with `hi`=32'hFFFFFFFF and `lo`=32'hFFFFFFEB.
- MULTU with A=B=32'hFFFFFFFF gives `hi`=32'hFFFFFFFE and `lo`=32'h00000001.
- DIV cases:
  - A=−7, B=2 gives `lo`=32'hFFFFFFFD and `hi`=32'hFFFFFFFF.
  - DIVU with A=100, B=0 gives `hi`=100, `lo`=32'hFFFFFFFF and `div_zero`=1, all in the `done` cycle.
  - DIV with A=32'h80000000, B=−1 gives `lo`=32'h80000000, `hi`=0 and `div_zero`=0.
- Flush and ignored start:
  - Start MULT 5×6, then assert `flush` 10 cycles later.
  - Required: no `done`, `hi`/`lo` unchanged, `busy`=0 next cycle.
  - A `start` asserted during `busy` is ignored.
- Back-to-back and moves:
  - MTHI 32'h1234 gives `hi`=32'h1234 one edge later, with `done` pulsed and `busy`=0.
  - A DIVU 9/4 start in a `done` cycle yields `lo`=2 and `hi`=1 after 33 cycles.
- Reset asserted mid-DIV:
  - All outputs clear immediately, with no `done`.
  - A subsequent MULT 3×3 gives `lo`=9 and `hi`=0.
